// File: rtl/morph_window_stream_pkg.sv
// rtl/morph_window_stream_pkg.sv - shared morphology mode encodings and element indexing
package morph_window_stream_pkg;

    typedef enum logic {
        MODE_DILATE = 1'b0,
        MODE_ERODE  = 1'b1
    } morph_mode_e;

    // y = 0 is the oldest row, x = 0 the oldest column; the live pixel is the top bit
    function automatic int elem_bit(input int y, input int x, input int kw);
        return y * kw + x;
    endfunction

endpackage

// File: rtl/morph_window_reduce.sv
// rtl/morph_window_reduce.sv - combinational dilate/erode reduction over a masked window
module morph_window_reduce
    import morph_window_stream_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] window,
    input  logic [N-1:0] element,
    input  logic [N-1:0] valid_mask,
    input  logic         mode,
    output logic         pixel
);

    logic dil;
    logic ero;

    // Masked-off positions act as padding: 0 for dilate, 1 for erode
    always_comb begin
        dil   = |(window & element & valid_mask);
        ero   = &(window | ~element | ~valid_mask);
        pixel = (mode == MODE_ERODE) ? ero : dil;
    end

endmodule

// File: rtl/morph_window_stream.sv
// rtl/morph_window_stream.sv - streaming binary dilate/erode with bottom-right anchored window
module morph_window_stream
    import morph_window_stream_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int K_W   = 3,
    parameter int K_H   = 3,
    parameter logic [K_W*K_H-1:0] ELEM_RST = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [K_W*K_H-1:0] cfg_element,
    input  logic               cfg_mode,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic               in_pixel,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_pixel
);

    localparam int N  = K_W * K_H;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = (K_H > 1) ? $clog2(K_H) : 1;
    localparam int LB = (K_H > 1) ? K_H - 1 : 1;
    localparam int WR = (K_W > 1) ? K_W - 1 : 1;

    logic [CW-1:0]              col_q;
    logic [RW-1:0]              row_q;
    logic                       first_q;
    logic [LB-1:0][IMG_W-1:0]   lb_q;
    logic [K_H-1:0][WR-1:0]     cw_q;
    logic [N-1:0]               elem_sh_q;
    logic [N-1:0]               elem_act_q;
    logic                       mode_sh_q;
    logic                       mode_act_q;

    logic                       sof_eff;
    logic [CW-1:0]              col_eff;
    logic [RW-1:0]              row_eff;
    logic                       last_col;
    logic [N-1:0]               elem_use;
    logic                       mode_use;
    logic [K_H-1:0]             cur_col;
    logic [N-1:0]               window;
    logic [N-1:0]               valid_mask;
    logic                       red_pixel;

    // The first pixel after reset starts a frame even without in_sof
    always_comb begin
        sof_eff  = in_sof | first_q;
        col_eff  = sof_eff ? '0 : col_q;
        row_eff  = sof_eff ? '0 : row_q;
        last_col = (col_eff == CW'(IMG_W - 1));
        elem_use = elem_act_q;
        mode_use = mode_act_q;
        if (in_valid && sof_eff) begin
            elem_use = cfg_load ? cfg_element : elem_sh_q;
            mode_use = cfg_load ? cfg_mode    : mode_sh_q;
        end
    end

    // Column-addressed line buffers: lb_q[j][c] holds column c of row r-1-j
    always_comb begin
        cur_col = '0;
        for (int y = 0; y < K_H; y++) begin
            if (y == K_H - 1)
                cur_col[y] = in_pixel;
            else
                cur_col[y] = lb_q[(y < K_H - 1) ? (K_H - 2 - y) : 0][col_eff];
        end
    end

    always_comb begin
        window     = '0;
        valid_mask = '0;
        for (int y = 0; y < K_H; y++) begin
            for (int x = 0; x < K_W; x++) begin
                int d;
                int e;
                d = K_W - 1 - x;
                e = K_H - 1 - y;
                window[elem_bit(y, x, K_W)]     = (d == 0) ? cur_col[y] : cw_q[y][(d > 0) ? d - 1 : 0];
                valid_mask[elem_bit(y, x, K_W)] = (d <= int'(col_eff)) && (e <= int'(row_eff));
            end
        end
    end

    morph_window_reduce #(
        .N(N)
    ) u_reduce (
        .window    (window),
        .element   (elem_use),
        .valid_mask(valid_mask),
        .mode      (mode_use),
        .pixel     (red_pixel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            first_q    <= 1'b1;
            lb_q       <= '0;
            cw_q       <= '0;
            elem_sh_q  <= ELEM_RST;
            elem_act_q <= ELEM_RST;
            mode_sh_q  <= MODE_DILATE;
            mode_act_q <= MODE_DILATE;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_pixel  <= 1'b0;
        end else begin
            if (cfg_load) begin
                elem_sh_q <= cfg_element;
                mode_sh_q <= cfg_mode;
            end
            out_valid <= in_valid;
            out_sof   <= in_valid & sof_eff;
            out_eol   <= in_valid & last_col;
            out_pixel <= in_valid & red_pixel;
            if (in_valid) begin
                first_q <= 1'b0;
                col_q   <= last_col ? '0 : col_eff + CW'(1);
                if (last_col && (int'(row_eff) < K_H - 1))
                    row_q <= row_eff + RW'(1);
                else
                    row_q <= row_eff;
                if (sof_eff) begin
                    elem_act_q <= elem_use;
                    mode_act_q <= mode_use;
                end
                for (int y = 0; y < K_H; y++) begin
                    cw_q[y][0] <= cur_col[y];
                    for (int k = 1; k < WR; k++)
                        cw_q[y][k] <= cw_q[y][k-1];
                end
                lb_q[0][col_eff] <= in_pixel;
                for (int j = 1; j < LB; j++)
                    lb_q[j][col_eff] <= lb_q[j-1][col_eff];
            end
        end
    end

endmodule

// File: tb/tb_morph_window_stream.sv
// tb/tb_morph_window_stream.sv - randomized self-checking bench for morph_window_stream
module tb_morph_window_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_load = 1'b0;
    logic [8:0] cfg_element = '0;
    logic       cfg_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_pixel = 1'b0;
    logic       out_valid;
    logic       out_sof;
    logic       out_eol;
    logic       out_pixel;

    int n_cmp = 0;
    int n_err = 0;
    bit [63:0] impulse_result;

    morph_window_stream #(
        .IMG_W(8),
        .K_W(3),
        .K_H(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_element(cfg_element),
        .cfg_mode   (cfg_mode),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_pixel  (out_pixel)
    );

    always #5 clk = ~clk;

    function automatic bit [63:0] model(input bit [63:0] img, input bit [8:0] elem, input bit mode);
        bit [63:0] res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                bit acc = mode;
                for (int y = 0; y < 3; y++) begin
                    for (int x = 0; x < 3; x++) begin
                        if (elem[y*3+x]) begin
                            int rr = r - 2 + y;
                            int cc = c - 2 + x;
                            bit v = (rr < 0 || cc < 0) ? mode : img[rr*8+cc];
                            if (mode) acc = acc & v;
                            else      acc = acc | v;
                        end
                    end
                end
                res[r*8+c] = acc;
            end
        end
        return res;
    endfunction

    task automatic step(input bit v, input bit s, input bit p, input bit ld, input bit [8:0] le,
                        input bit lm, output bit ov, output bit op, output bit os, output bit oe);
        in_valid = v; in_sof = s; in_pixel = p; cfg_load = ld; cfg_element = le; cfg_mode = lm;
        @(posedge clk);
        #1;
        ov = out_valid; op = out_pixel; os = out_sof; oe = out_eol;
        in_valid = 0; in_sof = 0; cfg_load = 0;
    endtask

    task automatic load_cfg(input bit [8:0] elem, input bit mode);
        bit ov, op, os, oe;
        step(0, 0, 0, 1, elem, mode, ov, op, os, oe);
        n_cmp++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL load_cfg out_valid got %0b want 0", ov);
        end
    endtask

    task automatic run_frame(input string name, input bit [63:0] img, input bit [8:0] elem,
                             input bit mode, input bit gaps, input bit bypass, output bit [63:0] got);
        bit [63:0] exp;
        bit ov, op, os, oe;
        int k = 0;
        exp = model(img, elem, mode);
        got = '0;
        while (k < 64) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                step(0, 0, 0, 0, elem, mode, ov, op, os, oe);
                n_cmp++;
                if (ov !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s gap out_valid got %0b want 0", name, ov);
                end
                continue;
            end
            step(1, k == 0, img[k], bypass && k == 0, elem, mode, ov, op, os, oe);
            n_cmp++;
            if (ov !== 1'b1 || op !== exp[k] || os !== (k == 0) || oe !== (k % 8 == 7)) begin
                n_err++;
                $display("FAIL %s px(%0d,%0d) got v=%0b p=%0b sof=%0b eol=%0b want v=1 p=%0b sof=%0b eol=%0b",
                         name, k / 8, k % 8, ov, op, os, oe, exp[k], k == 0, k % 8 == 7);
            end
            got[k] = op;
            k++;
        end
    endtask

    task automatic test_reset();
        bit ov, op, os, oe;
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1, 1, 9'h000, 1, ov, op, os, oe);
            n_cmp++;
            if (ov !== 1'b0) begin
                n_err++;
                $display("FAIL reset_override out_valid got %0b want 0", ov);
            end
        end
        rst = 0;
        step(0, 0, 0, 0, 9'h000, 0, ov, op, os, oe);
        n_cmp++;
        if (ov !== 1'b0 || op !== 1'b0 || os !== 1'b0 || oe !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got v=%0b p=%0b sof=%0b eol=%0b want all 0", ov, op, os, oe);
        end
    endtask

    task automatic test_dilate_impulse();
        bit [63:0] img = '0;
        bit [63:0] got;
        img[3*8+3] = 1;
        run_frame("dilate_impulse", img, 9'h1ff, 0, 0, 0, got);
        impulse_result = got;
        n_cmp++;
        if ($countones(got) != 9) begin
            n_err++;
            $display("FAIL dilate_impulse ones got %0d want 9", $countones(got));
        end
    endtask

    task automatic test_erode();
        bit [63:0] img = '1;
        bit [63:0] got;
        bit [63:0] want = '1;
        img[3*8+3] = 0;
        for (int r = 3; r <= 5; r++)
            for (int c = 3; c <= 5; c++)
                want[r*8+c] = 0;
        load_cfg(9'h1ff, 1);
        run_frame("erode", img, 9'h1ff, 1, 0, 0, got);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL erode_map got %h want %h", got, want);
        end
    endtask

    task automatic test_no_wrap();
        bit [63:0] img = '0;
        bit [63:0] got;
        bit [63:0] want = '0;
        img[2*8+7] = 1;
        want[2*8+7] = 1; want[3*8+7] = 1; want[4*8+7] = 1;
        load_cfg(9'h1ff, 0);
        run_frame("no_wrap", img, 9'h1ff, 0, 0, 0, got);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL no_wrap_map got %h want %h", got, want);
        end
    endtask

    task automatic test_element();
        bit [63:0] img = '0;
        bit [63:0] got;
        bit [63:0] want = '0;
        img[0] = 1;
        want[2*8+2] = 1;
        load_cfg(9'b000000001, 0);
        run_frame("element", img, 9'b000000001, 0, 0, 0, got);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL element_map got %h want %h", got, want);
        end
    endtask

    task automatic test_cfg_bypass();
        bit [63:0] got;
        bit [63:0] img;
        img = {$urandom, $urandom} | {$urandom, $urandom};
        run_frame("cfg_bypass", img, 9'h1ff, 1, 0, 1, got);
        img = {$urandom, $urandom} | {$urandom, $urandom};
        run_frame("cfg_persist", img, 9'h1ff, 1, 0, 0, got);
    endtask

    task automatic test_gaps();
        bit [63:0] img = '0;
        bit [63:0] got;
        img[3*8+3] = 1;
        load_cfg(9'h1ff, 0);
        run_frame("gaps", img, 9'h1ff, 0, 1, 0, got);
        n_cmp++;
        if (got !== impulse_result) begin
            n_err++;
            $display("FAIL gaps_map got %h want %h", got, impulse_result);
        end
    endtask

    task automatic test_restart();
        bit ov, op, os, oe;
        bit [63:0] got;
        bit [63:0] img;
        for (int i = 0; i < 20; i++)
            step(1, i == 0, 1'($urandom), 0, 9'h1ff, 0, ov, op, os, oe);
        img = {$urandom, $urandom} & {$urandom, $urandom};
        run_frame("restart", img, 9'h1ff, 0, 0, 0, got);
        load_cfg(9'h1ff, 1);
        for (int i = 0; i < 20; i++)
            step(1, i == 0, 1'($urandom), 0, 9'h1ff, 1, ov, op, os, oe);
        img = {$urandom, $urandom} | {$urandom, $urandom};
        run_frame("restart_erode", img, 9'h1ff, 1, 0, 0, got);
    endtask

    task automatic test_random();
        bit [63:0] got;
        for (int i = 0; i < 6; i++) begin
            bit [8:0] elem = 9'($urandom);
            bit mode = 1'($urandom);
            bit [63:0] img = {$urandom, $urandom};
            load_cfg(elem, mode);
            run_frame("random", img, elem, mode, 1'(i % 2), 0, got);
        end
    endtask

    initial begin
        test_reset();
        test_dilate_impulse();
        test_erode();
        test_no_wrap();
        test_element();
        test_cfg_bypass();
        test_gaps();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/morph_window_stream.md
MORPH_WINDOW_STREAM -- requirements
Module: morph_window_stream

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IMG_W, 8, image width in pixels (>=2).
- K_W, 3, window width (1..IMG_W).
- K_H, 3, window height (>=1).
- ELEM_RST, all ones (K_W*K_H bits), element loaded at reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, reset, synchronous and active-high.
- cfg_load, in, 1, capture cfg_element/cfg_mode into the shadow registers.
- cfg_element, in, K_W*K_H, structuring element.
- cfg_mode, in, 1, 0 = dilate, 1 = erode.
- in_valid, in, 1, in_pixel valid this cycle.
- in_sof, in, 1, qualified pixel is (row 0, col 0) of a frame.
- in_pixel, in, 1, binary pixel, raster order.
- out_valid, out, 1, result valid.
- out_sof, out, 1, result belongs to pixel (0,0).
- out_eol, out, 1, result belongs to the last column.
- out_pixel, out, 1, morphology result.

Function
REQ-003 The window SHALL be anchored bottom-right: the result for input (r,c) covers rows r-K_H+1..r and columns c-K_W+1..c.
REQ-004 Element bit index SHALL be y*K_W+x, with y=0 the oldest row and x=0 the oldest column; bit K_W*K_H-1 is the current pixel.
REQ-005 Dilate SHALL be the OR over the set element bits of the window pixels; erode SHALL be the AND over the set element bits of the window pixels. An all-zero element yields 0 for dilate and 1 for erode.
REQ-006 Window positions outside the image SHALL read as the padding value: 0 for dilate, 1 for erode (padding = active mode).
REQ-007 Latency SHALL be exactly 1 cycle: out_valid, out_sof, out_eol and out_pixel are registered from the in_valid cycle. out_valid SHALL be 0 in any cycle after an in_valid=0 cycle.
REQ-008 in_valid gaps of any length SHALL NOT change the result sequence. Window and history state SHALL advance only on in_valid.
REQ-009 The column counter SHALL run 0..IMG_W-1 and wrap to 0; the row index SHALL advance on the wrap. The row count SHALL saturate at K_H-1.
REQ-010 Columns SHALL NOT wrap into the window. Columns c-k<0 are padding even though the previous row's tail is in the shift history.
REQ-011 in_sof with in_valid SHALL force (0,0) for that pixel, including mid-frame. All previous history SHALL read as padding for the new frame.
REQ-012 The active element and mode SHALL update from the shadow registers only on an in_sof pixel.
REQ-013 When cfg_load and in_sof are high in the same cycle, the newly presented values SHALL apply to that frame (bypass).
REQ-014 The line history SHALL be K_H-1 buffers of IMG_W bits each. The column window SHALL be K_W-1 registers per row plus the live pixel.

Reset
REQ-015 On rst the following SHALL clear: all outputs to 0, counters to 0, history to 0, active and shadow element to ELEM_RST, active and shadow mode to 0.
REQ-016 rst SHALL override simultaneous in_valid and cfg_load. The first valid pixel after reset SHALL be treated as (0,0) whether or not in_sof is asserted.

Structure
REQ-017 The shared morphology package/header SHALL hold the mode encodings (MODE_DILATE=0, MODE_ERODE=1) and the element bit-index macro.
REQ-018 The reduction SHALL be one combinational sub-module, morph_window_reduce (window, element, mode, valid-mask -> pixel). The line buffers, counters and registers SHALL stay in the top module.

Verification (IMG_W=8, K_W=K_H=3, full element unless stated)
REQ-019 Reset and idle: rst high 2 cycles, then in_valid=0 -> out_valid=0, out_pixel=0, out_sof=0.
REQ-020 Dilate impulse: 8x8 zeros with (3,3)=1 -> exactly 9 ones at rows 3..5, cols 3..5. out_sof on the result for (0,0); out_eol every 8th result.
REQ-021 Erode: 8x8 ones with (3,3)=0, mode 1 -> zeros exactly at rows 3..5, cols 3..5, all others 1 (borders 1 via padding).
REQ-022 No wrap: dilate with (2,7)=1 -> ones only at (2,7), (3,7), (4,7). Cols 0..1 of rows 3..4 stay 0.
REQ-023 Element/config: element=9'b000000001, dilate, (0,0)=1 -> single one at (2,2). cfg_load on the in_sof cycle with erode applies to the same frame.
REQ-024 Gaps and restart: the same frame with in_valid at 50% random duty -> results identical to REQ-020. in_sof at pixel 20 -> history cleared and output matches a fresh frame.
